// File: rtl/ram_1port_arb2.sv
// ram_1port_arb2: two-requester arbiter in front of a single-port RAM, acks routed back in order via a tag FIFO.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise p0 has fixed priority.
module ram_1port_arb2 #(
  parameter int Width = 16,
  parameter int AddrBits = 8,
  parameter int TagDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_req_valid,
  input  logic                p0_req_we,
  input  logic [AddrBits-1:0] p0_req_addr,
  input  logic [Width-1:0]    p0_req_data,
  output logic                p0_req_retry,
  output logic                p0_ack_valid,
  output logic [Width-1:0]    p0_ack_data,
  input  logic                p0_ack_retry,
  input  logic                p1_req_valid,
  input  logic                p1_req_we,
  input  logic [AddrBits-1:0] p1_req_addr,
  input  logic [Width-1:0]    p1_req_data,
  output logic                p1_req_retry,
  output logic                p1_ack_valid,
  output logic [Width-1:0]    p1_ack_data,
  input  logic                p1_ack_retry,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [AddrBits-1:0] mem_req_addr,
  output logic [Width-1:0]    mem_req_data,
  input  logic                mem_req_retry,
  input  logic                mem_ack_valid,
  input  logic [Width-1:0]    mem_ack_data,
  output logic                mem_ack_retry,
  output logic                err_orphan_ack
);
`ifdef RAM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif
  localparam int PtrBits = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  logic [TagDepth-1:0] r_tags;
  logic [PtrBits-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PtrBits:0]    r_count;
  logic r_last, r_lock, r_lock_id, r_err;
  logic w_full, w_empty, w_head, w_win_valid, w_win_id, w_push, w_pop, w_ack_live;
  always_comb begin
    w_full = r_count == (PtrBits+1)'(TagDepth);
    w_empty = r_count == '0;
    w_head = r_tags[r_rd_ptr];
    w_win_valid = p0_req_valid | p1_req_valid;
    // a stalled winner keeps the grant for as long as it keeps asking
    w_win_id = (r_lock && (r_lock_id ? p1_req_valid : p0_req_valid)) ? r_lock_id :
               (p0_req_valid && p1_req_valid) ? (RrEn ? ~r_last : 1'b0) : ~p0_req_valid;
    mem_req_valid = ~reset & w_win_valid & ~w_full;
    mem_req_we = w_win_id ? p1_req_we : p0_req_we;
    mem_req_addr = w_win_id ? p1_req_addr : p0_req_addr;
    mem_req_data = w_win_id ? p1_req_data : p0_req_data;
    w_push = mem_req_valid & ~mem_req_retry;
    p0_req_retry = ~(w_push & ~w_win_id);
    p1_req_retry = ~(w_push & w_win_id);
    w_ack_live = ~reset & ~w_empty;
    p0_ack_valid = w_ack_live & mem_ack_valid & ~w_head;
    p1_ack_valid = w_ack_live & mem_ack_valid & w_head;
    p0_ack_data = mem_ack_data;
    p1_ack_data = mem_ack_data;
    mem_ack_retry = w_ack_live & (w_head ? p1_ack_retry : p0_ack_retry);
    w_pop = w_ack_live & mem_ack_valid & ~mem_ack_retry;
    err_orphan_ack = r_err;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tags <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_last <= 1'b1;
      r_lock <= 1'b0;
      r_lock_id <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_win_id;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last <= w_win_id;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PtrBits+1)'(w_push) - (PtrBits+1)'(w_pop);
      r_lock <= w_win_valid & ~w_push;
      r_lock_id <= w_win_id;
      if (mem_ack_valid & w_empty) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_ram_1port_arb2.sv
// tb_ram_1port_arb2: directed plus randomized checks of ram_1port_arb2 against a queue-based reference model.
module tb_ram_1port_arb2;
  localparam int TD = 4;
  typedef struct packed { logic port; logic [15:0] data; } ent_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] p_v = '0, p_we = '0, p_ar = '0;
  logic [7:0] p_addr [2];
  logic [15:0] p_data [2];
  logic m_rr = 1'b0, m_av = 1'b0;
  logic [15:0] m_ad = '0;
  logic p0_req_retry, p1_req_retry, p0_ack_valid, p1_ack_valid;
  logic [15:0] p0_ack_data, p1_ack_data, mem_req_data;
  logic mem_req_valid, mem_req_we, mem_ack_retry, err_orphan_ack;
  logic [7:0] mem_req_addr;
  int checks = 0, errors = 0;
  ent_t q[$], dlv[$];
  int grants[$];
  int acc[2];
  int mar_cnt, p0av_cnt, ack_mode;
  logic [15:0] ram [256];
  logic [1:0] refill = '0;
  bit tb_last = 1'b1, lock_v = 1'b0, lock_id = 1'b0, err_m = 1'b0;

  ram_1port_arb2 dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p_v[0]), .p0_req_we(p_we[0]), .p0_req_addr(p_addr[0]), .p0_req_data(p_data[0]),
    .p0_req_retry(p0_req_retry), .p0_ack_valid(p0_ack_valid), .p0_ack_data(p0_ack_data), .p0_ack_retry(p_ar[0]),
    .p1_req_valid(p_v[1]), .p1_req_we(p_we[1]), .p1_req_addr(p_addr[1]), .p1_req_data(p_data[1]),
    .p1_req_retry(p1_req_retry), .p1_ack_valid(p1_ack_valid), .p1_ack_data(p1_ack_data), .p1_ack_retry(p_ar[1]),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_retry(m_rr), .mem_ack_valid(m_av), .mem_ack_data(m_ad), .mem_ack_retry(mem_ack_retry),
    .err_orphan_ack(err_orphan_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(int n);
    p_v[n] = 1'b1;
    p_we[n] = 1'($urandom);
    p_addr[n] = 8'($urandom_range(0, 15));
    p_data[n] = 16'($urandom);
  endtask

  function automatic int exp_win();
    if (lock_v && p_v[lock_id]) return int'(lock_id);
    if (p_v[0] && p_v[1]) begin
`ifdef RAM_ARB_RR_EN
      return int'(!tb_last);
`else
      return 0;
`endif
    end
    if (p_v[0]) return 0;
    if (p_v[1]) return 1;
    return -1;
  endfunction

  task automatic cycle();
    int w;
    bit full, push, pop, hp, live;
    ent_t e;
    if (ack_mode == 1) m_av = q.size() > 0;
    else if (ack_mode == 2) m_av = q.size() > 0 && $urandom_range(0, 3) != 0;
    else if (ack_mode == 0) m_av = 1'b0;
    m_ad = q.size() > 0 ? q[0].data : 16'($urandom);
    #4;
    w = exp_win();
    full = q.size() == TD;
    live = q.size() > 0;
    hp = live ? q[0].port : 1'b0;
    push = w >= 0 && !full && !m_rr;
    pop = m_av && live && !p_ar[hp];
    chk("mem_req_valid", 32'(mem_req_valid), 32'(w >= 0 && !full));
    if (w >= 0) begin
      chk("mem_req_we", 32'(mem_req_we), 32'(p_we[w]));
      chk("mem_req_addr", 32'(mem_req_addr), 32'(p_addr[w]));
      chk("mem_req_data", 32'(mem_req_data), 32'(p_data[w]));
    end
    chk("p0_req_retry", 32'(p0_req_retry), 32'(!(push && w == 0)));
    chk("p1_req_retry", 32'(p1_req_retry), 32'(!(push && w == 1)));
    chk("p0_ack_valid", 32'(p0_ack_valid), 32'(m_av && live && !hp));
    chk("p1_ack_valid", 32'(p1_ack_valid), 32'(m_av && live && hp));
    chk("mem_ack_retry", 32'(mem_ack_retry), 32'(live && p_ar[hp]));
    chk("err_orphan_ack", 32'(err_orphan_ack), 32'(err_m));
    if (m_av && live) chk("ack_data", 32'(hp ? p1_ack_data : p0_ack_data), 32'(q[0].data));
    if (mem_ack_retry) mar_cnt++;
    if (p0_ack_valid) p0av_cnt++;
    if (pop) begin
      e.port = hp;
      e.data = hp ? p1_ack_data : p0_ack_data;
      dlv.push_back(e);
    end
    @(posedge clk);
    #1;
    if (m_av && !live) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.port = w[0];
      e.data = p_we[w] ? 16'h0 : ram[p_addr[w]];
      if (p_we[w]) ram[p_addr[w]] = p_data[w];
      q.push_back(e);
      tb_last = w[0];
      grants.push_back(w);
      acc[w]++;
      if (refill[w]) new_req(w);
      else p_v[w] = 1'b0;
    end
    lock_v = w >= 0 && !push;
    lock_id = w[0];
  endtask

  task automatic do_reset();
    p_v = 2'b11;
    p_ar = 2'b11;
    m_av = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    chk("rst_p0_req_retry", 32'(p0_req_retry), 32'(1));
    chk("rst_p1_req_retry", 32'(p1_req_retry), 32'(1));
    chk("rst_ack_valid", 32'({p1_ack_valid, p0_ack_valid}), 32'(0));
    chk("rst_mem_ack_retry", 32'(mem_ack_retry), 32'(0));
    chk("rst_err", 32'(err_orphan_ack), 32'(0));
    @(posedge clk);
    #1;
    chk("rst_err_held", 32'(err_orphan_ack), 32'(0));
    reset = 1'b0;
    p_v = '0;
    p_ar = '0;
    m_av = 1'b0;
    m_rr = 1'b0;
    refill = '0;
    ack_mode = 0;
    q.delete();
    lock_v = 1'b0;
    tb_last = 1'b1;
    err_m = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 2; i++) begin p_addr[i] = '0; p_data[i] = '0; end
    do_reset();
    // orphan ack after reset
    ack_mode = 3;
    m_av = 1'b1;
    cycle();
    m_av = 1'b0;
    repeat (3) cycle();
    chk("orphan_sticky", 32'(err_orphan_ack), 32'(1));
    do_reset();
    // write then read-back through the other port
    p_v[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 8'h10; p_data[0] = 16'hBEEF;
    cycle();
    p_v[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 8'h10;
    cycle();
    dlv.delete();
    ack_mode = 1;
    repeat (4) cycle();
    chk("fwd_count", 32'(dlv.size()), 32'(2));
    chk("fwd_first_port", 32'(dlv[0].port), 32'(0));
    chk("fwd_second_port", 32'(dlv[1].port), 32'(1));
    chk("fwd_read_data", 32'(dlv[1].data), 32'h0000BEEF);
    // tag FIFO fills at TD outstanding requests
    do_reset();
    refill[0] = 1'b1;
    new_req(0);
    repeat (8) cycle();
    chk("full_accepts", 32'(acc[0]), 32'(TD));
    ack_mode = 3;
    m_av = 1'b1;
    cycle();
    chk("full_no_grant_on_pop", 32'(acc[0]), 32'(TD));
    m_av = 1'b0;
    cycle();
    chk("full_after_pop", 32'(acc[0]), 32'(TD + 1));
    p_v[0] = 1'b0;
    refill[0] = 1'b0;
    ack_mode = 1;
    repeat (6) cycle();
    // head port stalls its ack
    do_reset();
    p_v[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 8'h03;
    cycle();
    p_v[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 8'h04;
    cycle();
    mar_cnt = 0;
    p0av_cnt = 0;
    dlv.delete();
    p_ar[1] = 1'b1;
    ack_mode = 1;
    repeat (3) cycle();
    chk("stall_retry_cycles", 32'(mar_cnt), 32'(3));
    chk("stall_no_p0_ack", 32'(p0av_cnt), 32'(0));
    chk("stall_no_delivery", 32'(dlv.size()), 32'(0));
    p_ar[1] = 1'b0;
    repeat (3) cycle();
    chk("stall_order_len", 32'(dlv.size()), 32'(2));
    chk("stall_order_first", 32'(dlv[0].port), 32'(1));
    chk("stall_order_second", 32'(dlv[1].port), 32'(0));
    // both requesters continuously valid
    do_reset();
    ack_mode = 1;
    refill = 2'b11;
    new_req(0);
    new_req(1);
    grants.delete();
    repeat (8) cycle();
    chk("conflict_grants", 32'(grants.size()), 32'(8));
    chk("conflict_first", 32'(grants[0]), 32'(0));
    for (int i = 1; i < grants.size(); i++) begin
`ifdef RAM_ARB_RR_EN
      chk("rr_alternate", 32'(grants[i]), 32'(1 - grants[i-1]));
`else
      chk("fixed_p0_only", 32'(grants[i]), 32'(0));
`endif
    end
    refill[0] = 1'b0;
    p_v[0] = 1'b0;
    grants.delete();
    repeat (3) cycle();
    chk("p1_after_p0_drops", 32'(grants[0]), 32'(1));
    p_v = '0;
    refill = '0;
    repeat (3) cycle();
    // reset with outstanding tags discards them
    do_reset();
    refill[0] = 1'b1;
    new_req(0);
    repeat (3) cycle();
    do_reset();
    ack_mode = 3;
    m_av = 1'b1;
    cycle();
    m_av = 1'b0;
    cycle();
    chk("post_reset_orphan", 32'(err_orphan_ack), 32'(1));
    refill[0] = 1'b1;
    new_req(0);
    repeat (6) cycle();
    chk("post_reset_accepts", 32'(acc[0]), 32'(TD));
    p_v[0] = 1'b0;
    refill[0] = 1'b0;
    ack_mode = 1;
    repeat (6) cycle();
    // randomized traffic
    do_reset();
    ack_mode = 2;
    for (int n = 0; n < 600; n++) begin
      m_rr = $urandom_range(0, 3) == 0;
      for (int i = 0; i < 2; i++) begin
        p_ar[i] = $urandom_range(0, 4) == 0;
        if (!p_v[i] && $urandom_range(0, 2) == 0) new_req(i);
        else if (p_v[i] && $urandom_range(0, 29) == 0) p_v[i] = 1'b0;
      end
      cycle();
    end
    m_rr = 1'b0;
    p_ar = '0;
    p_v = '0;
    ack_mode = 1;
    repeat (6) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_1port_arb2.md
RAM_1PORT_ARB2 -- requirements
Module: ram_1port_arb2

Interface
REQ-001 Parameter Width, default 16, data width of all data ports.
REQ-002 Parameter AddrBits, default 8, address width of all address ports.
REQ-003 Parameter TagDepth, default 4, number of outstanding requests tracked (power of 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 pN_req_valid, pN_req_we (N=0,1)  input  1 each  requester N request valid, write enable.
REQ-007 pN_req_addr  input  AddrBits; pN_req_data  input  Width.
REQ-008 pN_req_retry  output  1  high = requester N request not taken this cycle.
REQ-009 pN_ack_valid  output  1; pN_ack_data  output  Width; pN_ack_retry  input  1.
REQ-010 mem_req_valid, mem_req_we  output  1; mem_req_addr  output  AddrBits; mem_req_data  output  Width.
REQ-011 mem_req_retry  input  1  RAM refuses request.
REQ-012 mem_ack_valid  input  1; mem_ack_data  input  Width; mem_ack_retry  output  1.
REQ-013 err_orphan_ack  output  1  sticky, ack seen with no outstanding request.

Function
REQ-014 A transfer occurs on any channel when valid=1 and retry=0 in the same cycle.
REQ-015 Request path is combinational: zero added latency from pN_req to mem_req.
REQ-016 The block shall pick a winner among valid requesters each cycle; mem_req_* shall carry the winner's we/addr/data and mem_req_valid = winner exists and tag FIFO not full.
REQ-017 pN_req_retry = 0 only when N is the winner, tag FIFO not full, and mem_req_retry = 0; otherwise 1.
REQ-018 On each mem request transfer, the winner ID (1 bit) shall be pushed into the tag FIFO.
REQ-019 Every accepted request, read or write, yields exactly one mem ack, in order.
REQ-020 Ack routing: pN_ack_valid = mem_ack_valid and FIFO non-empty and head ID = N; pN_ack_data = mem_ack_data; mem_ack_retry = head port's pN_ack_retry.
REQ-021 FIFO head shall pop on mem ack transfer.
REQ-022 FIFO full: no new grant even if a pop occurs the same cycle; simultaneous push and pop when not full keeps count unchanged.
REQ-023 mem_ack_valid with FIFO empty: no pN_ack_valid, mem_ack_retry = 0, err_orphan_ack set to 1 next cycle and held until reset.
REQ-024 Arbitration pointer updates only on a mem request transfer, never on a refused attempt.
REQ-025 Winner shall hold while its valid stays high and it is retried (no grant switching under a stalled winner).

Reset
REQ-026 While reset high: FIFO empty, pointer favours p0, err_orphan_ack = 0.
REQ-027 Outputs during reset: mem_req_valid = 0, pN_req_retry = 1, pN_ack_valid = 0, mem_ack_retry = 0.
REQ-028 Reset mid-operation discards all outstanding tags; later acks count as orphans.

Configuration
REQ-029 Macro RAM_ARB_RR_EN defined: round-robin, the requester not granted last transfer wins on conflict.
REQ-030 RAM_ARB_RR_EN undefined: fixed priority, p0 always wins on conflict; REQ-025 still applies.

Verification
REQ-031 p0 write addr 0x10 data 0xBEEF, then p1 read 0x10 (RAM Forward-capable) -> p1_ack_data 0xBEEF, p0 gets write ack only.
REQ-032 Both valid continuously, RR build, mem_req_retry 0 -> grants alternate p0,p1,p0,p1; fixed build -> p0 only until p0 drops.
REQ-033 mem_ack_valid held 0, 5 requests issued -> exactly 4 accepted, 5th retried until one ack pops.
REQ-034 p1 ack_retry held 1 three cycles with p1 at head -> mem_ack_retry 1 three cycles, p0 ack not delivered ahead of it.
REQ-035 mem_ack_valid pulse after reset with no requests -> err_orphan_ack 1 next cycle, stays 1.
REQ-036 Reset asserted with 3 tags outstanding -> all outputs to REQ-027 values immediately, FIFO count 0 after release.
